b2_demux_1_3_reg: RTL and testbench
===================================

B2_DEMUX_1_3_REG -- requirements
Module: b2_demux_1_3_reg

Interface
REQ-001 Parameter: ERR_W, default 4, width of the illegal-select error counter.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 d  input  2  data beat to route.
REQ-005 sel  input  2  destination select: 00 -> ch0, 01 -> ch1, 10 -> ch2, 11 illegal.
REQ-006 in_valid  input  1  beat on d/sel is valid.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 y0, y1, y2  output  2 each  channel data registers.
REQ-009 v0, v1, v2  output  1 each  channel holds a valid beat.
REQ-010 r0, r1, r2  input  1 each  channel consumer ready.
REQ-011 err_cnt  output  ERR_W  count of dropped illegal-select beats.

Function
REQ-012 Each channel SHALL have a one-entry holding register (yN, vN); the entry is full when vN=1.
REQ-013 Accept condition SHALL be in_valid & in_ready.
REQ-014 in_ready SHALL be combinational: 1 when sel=11; otherwise (~vN | rN) for the channel N selected by sel.
REQ-015 For an accepted legal beat, yN SHALL load d and vN SHALL be 1 on the next rising edge: 1-cycle latency, d to yN.
REQ-016 A channel transfer SHALL occur on cycles where vN & rN.
REQ-017 If a transfer occurs and no new beat is accepted into the same channel, vN SHALL clear on that edge.
REQ-018 If a transfer and an accept target the same channel in one cycle, yN SHALL take the new d and vN SHALL stay 1. This gives full throughput per channel.
REQ-019 yN SHALL hold its value while vN=1 and rN=0, and SHALL hold its last value after vN clears.
REQ-020 Channels SHALL be independent: a stalled channel never blocks a beat to another channel.
REQ-021 An accepted beat with sel=11 SHALL be dropped. No channel state changes. err_cnt increments by 1.
REQ-022 err_cnt SHALL saturate at 2^ERR_W-1 with no wrap-around.
REQ-023 in_valid=0 SHALL cause no state change, except channel drains per REQ-017.
REQ-024 d and sel SHALL be ignored whenever in_valid=0.

Reset
REQ-025 While rst=1, asynchronously, all outputs SHALL clear: v0..v2=0, y0..y2=00, err_cnt=0.
REQ-026 Reset asserted mid-operation SHALL discard all held beats; no transfer occurs on that cycle.
REQ-027 After rst deasserts, the first accept SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-028 Reset: drive rst=1 mid-cycle with v1=1 -> v0..v2=0, y*=00, err_cnt=0 immediately, before the next edge.
REQ-029 Routing: r0..r2=1; beats (d=01,sel=00), (d=10,sel=01), (d=11,sel=10) on consecutive cycles -> y0=01/v0=1, y1=10/v1=1, y2=11/v2=1, each one cycle after its accept.
REQ-030 Backpressure: r1=0, send d=10 to ch1, then d=01 to ch1 -> second beat sees in_ready=0 and y1 holds 10. Raise r1 -> transfer of 10, then 01 is accepted.
REQ-031 Simultaneous drain and accept: v2=1, y2=00, r2=1, accept d=11 sel=10 -> y2=11, v2 stays 1.
REQ-032 Independence: r0=0 with v0=1; beat to ch2 -> accepted with in_ready=1 and v2=1 next cycle.
REQ-033 Illegal select: 20 beats with sel=11 and ERR_W=4 -> in_ready=1 every cycle, err_cnt=15 and holds, all vN unchanged.

Source files
------------

// File: rtl/b2_demux_1_3_reg.sv
// rtl/b2_demux_1_3_reg.sv - 1-to-3 registered demultiplexer with per-channel holding registers
//
// Purpose: routes a 2-bit beat on d to one of three one-entry channel
// registers chosen by sel. Each channel drains independently through its own
// valid/ready pair. Beats with the illegal select 11 are dropped and counted.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   d         data beat to route
//   sel       destination select (00 ch0, 01 ch1, 10 ch2, 11 illegal)
//   in_valid  beat on d/sel is valid
//   in_ready  block accepts the beat this cycle (combinational)
//   y0..y2    channel data registers
//   v0..v2    channel holds a valid beat
//   r0..r2    channel consumer ready
//   err_cnt   saturating count of dropped illegal-select beats

module b2_demux_1_3_reg #(
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       d,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       y0,
    output logic [1:0]       y1,
    output logic [1:0]       y2,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [1:0]       SEL_BAD = 2'b11;

    logic [1:0] y_q [3];
    logic [2:0] v_q;
    logic [2:0] r_vec;
    logic [2:0] load;
    logic       accept;

    assign r_vec = {r2, r1, r0};

    // A full channel can still take a beat when its consumer drains it on the
    // same edge, which keeps each channel at one beat per cycle.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            2'b00:   in_ready = ~v_q[0] | r_vec[0];
            2'b01:   in_ready = ~v_q[1] | r_vec[1];
            2'b10:   in_ready = ~v_q[2] | r_vec[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load = 3'b000;
        if (accept) begin
            case (sel)
                2'b00:   load = 3'b001;
                2'b01:   load = 3'b010;
                2'b10:   load = 3'b100;
                default: load = 3'b000;
            endcase
        end
    end

    // A new beat wins over a drain; y holds its last value once v clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                y_q[i] <= 2'b00;
            end
            v_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    y_q[i] <= d;
                    v_q[i] <= 1'b1;
                end else if (v_q[i] && r_vec[i]) begin
                    v_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && (sel == SEL_BAD) && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_ONE;
        end
    end

    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign v0 = v_q[0];
    assign v1 = v_q[1];
    assign v2 = v_q[2];

endmodule

// File: tb/tb_b2_demux_1_3_reg.sv
// tb/tb_b2_demux_1_3_reg.sv - directed self-checking bench for b2_demux_1_3_reg

module tb_b2_demux_1_3_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] d;
    logic [1:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] y0, y1, y2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic [3:0] err_cnt;

    int errors = 0;
    int checks = 0;

    b2_demux_1_3_reg #(.ERR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .v0       (v0),
        .v1       (v1),
        .v2       (v2),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d = 2'b11; sel = 2'b00; in_valid = 1'b1;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        step();
        step();
        checks++; if ({v2, v1, v0} !== 3'b000) begin errors++; $display("FAIL reset_v got=%b exp=000", {v2, v1, v0}); end
        checks++; if ({y2, y1, y0} !== 6'b0) begin errors++; $display("FAIL reset_y got=%b exp=000000", {y2, y1, y0}); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        // Release mid-cycle with a beat pending: nothing may load before the next edge.
        #2 rst = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL release_no_early_accept got=%b exp=0", v0); end
        step();
        checks++; if (v0 !== 1'b1 || y0 !== 2'b11) begin errors++; $display("FAIL release_first_accept got=v%b y%b exp=v1 y11", v0, y0); end
        in_valid = 1'b0;
        step();
        checks++; if (v0 !== 1'b0 || y0 !== 2'b11) begin errors++; $display("FAIL drain_hold got=v%b y%b exp=v0 y11", v0, y0); end
    endtask

    task automatic test_routing();
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        in_valid = 1'b1; d = 2'b01; sel = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_rdy0 got=%b exp=1", in_ready); end
        step();
        checks++; if (y0 !== 2'b01 || v0 !== 1'b1) begin errors++; $display("FAIL route_ch0 got=y%b v%b exp=y01 v1", y0, v0); end
        d = 2'b10; sel = 2'b01;
        step();
        checks++; if (y1 !== 2'b10 || v1 !== 1'b1) begin errors++; $display("FAIL route_ch1 got=y%b v%b exp=y10 v1", y1, v1); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL route_ch0_drained got=%b exp=0", v0); end
        d = 2'b11; sel = 2'b10;
        step();
        checks++; if (y2 !== 2'b11 || v2 !== 1'b1) begin errors++; $display("FAIL route_ch2 got=y%b v%b exp=y11 v1", y2, v2); end
        in_valid = 1'b0; d = 2'b00; sel = 2'b00;
        step();
        checks++; if ({v2, v1, v0} !== 3'b000) begin errors++; $display("FAIL route_idle_v got=%b exp=000", {v2, v1, v0}); end
        checks++; if ({y2, y1, y0} !== 6'b11_10_01) begin errors++; $display("FAIL route_idle_y got=%b exp=111001", {y2, y1, y0}); end
    endtask

    task automatic test_backpressure();
        r1 = 1'b0;
        in_valid = 1'b1; d = 2'b10; sel = 2'b01;
        step();
        checks++; if (y1 !== 2'b10 || v1 !== 1'b1) begin errors++; $display("FAIL bp_first got=y%b v%b exp=y10 v1", y1, v1); end
        d = 2'b01;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_rdy got=%b exp=0", in_ready); end
        step();
        checks++; if (y1 !== 2'b10 || v1 !== 1'b1) begin errors++; $display("FAIL bp_hold got=y%b v%b exp=y10 v1", y1, v1); end
        r1 = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", in_ready); end
        step();
        checks++; if (y1 !== 2'b01 || v1 !== 1'b1) begin errors++; $display("FAIL bp_second got=y%b v%b exp=y01 v1", y1, v1); end
        in_valid = 1'b0;
        step();
        checks++; if (v1 !== 1'b0 || y1 !== 2'b01) begin errors++; $display("FAIL bp_drain got=y%b v%b exp=y01 v0", y1, v1); end
    endtask

    task automatic test_back_to_back();
        r2 = 1'b0;
        in_valid = 1'b1; d = 2'b00; sel = 2'b10;
        step();
        checks++; if (y2 !== 2'b00 || v2 !== 1'b1) begin errors++; $display("FAIL b2b_setup got=y%b v%b exp=y00 v1", y2, v2); end
        r2 = 1'b1; d = 2'b11;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy got=%b exp=1", in_ready); end
        step();
        checks++; if (y2 !== 2'b11 || v2 !== 1'b1) begin errors++; $display("FAIL b2b_replace got=y%b v%b exp=y11 v1", y2, v2); end
        in_valid = 1'b0;
        step();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", v2); end
    endtask

    task automatic test_independence();
        r0 = 1'b0;
        in_valid = 1'b1; d = 2'b01; sel = 2'b00;
        step();
        checks++; if (v0 !== 1'b1 || y0 !== 2'b01) begin errors++; $display("FAIL ind_stall_ch0 got=y%b v%b exp=y01 v1", y0, v0); end
        d = 2'b10; sel = 2'b10;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ind_rdy got=%b exp=1", in_ready); end
        step();
        checks++; if (v2 !== 1'b1 || y2 !== 2'b10) begin errors++; $display("FAIL ind_ch2 got=y%b v%b exp=y10 v1", y2, v2); end
        checks++; if (v0 !== 1'b1 || y0 !== 2'b01) begin errors++; $display("FAIL ind_ch0_held got=y%b v%b exp=y01 v1", y0, v0); end
        in_valid = 1'b0;
        step();
        checks++; if ({v2, v1, v0} !== 3'b001) begin errors++; $display("FAIL ind_after got=%b exp=001", {v2, v1, v0}); end
    endtask

    // Runs with ch0 still stalled and full from test_independence.
    task automatic test_illegal();
        logic [3:0] exp_err;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; sel = 2'b11; d = 2'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_rdy beat=%0d got=%b exp=1", i, in_ready); end
            step();
            exp_err = (i >= 14) ? 4'd15 : 4'(i + 1);
            checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL illegal_cnt beat=%0d got=%0d exp=%0d", i, err_cnt, exp_err); end
        end
        in_valid = 1'b0;
        checks++; if ({v2, v1, v0} !== 3'b001 || y0 !== 2'b01) begin errors++; $display("FAIL illegal_state got=v%b y0=%b exp=v001 y0=01", {v2, v1, v0}, y0); end
        // Illegal select with in_valid low must not count either.
        step();
        checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL illegal_hold got=%0d exp=15", err_cnt); end
    endtask

    task automatic test_reset_mid();
        r0 = 1'b1; r1 = 1'b0;
        in_valid = 1'b1; d = 2'b10; sel = 2'b01;
        step();
        in_valid = 1'b0;
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL mid_setup got=%b exp=1", v1); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({v2, v1, v0} !== 3'b000) begin errors++; $display("FAIL mid_v got=%b exp=000", {v2, v1, v0}); end
        checks++; if ({y2, y1, y0} !== 6'b0) begin errors++; $display("FAIL mid_y got=%b exp=000000", {y2, y1, y0}); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL mid_err got=%0d exp=0", err_cnt); end
        step();
        rst = 1'b0;
        step();
        checks++; if ({v2, v1, v0} !== 3'b000) begin errors++; $display("FAIL mid_post got=%b exp=000", {v2, v1, v0}); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_independence();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
